// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg: shared state encoding, default address base and MEM/WB bubble for the memory-access stage.
// Rev 1.0
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int unsigned DEFAULT_ADDR_BASE = 32'd1024;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
    logic [3:0]  dest;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// mem_wb_reg: MEM/WB pipeline register with synchronous bubble insertion and async active-low reset.
// Rev 1.0
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble_i,
  input  logic        wb_en_i,
  input  logic        mem_r_en_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] mem_data_i,
  input  logic [3:0]  dest_i,
  output logic        wb_en_o,
  output logic        mem_r_en_o,
  output logic [31:0] alu_res_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  dest_o
);

  mem_wb_t wb_d;
  mem_wb_t wb_q;

  always_comb begin
    wb_d = {wb_en_i, mem_r_en_i, alu_res_i, mem_data_i, dest_i};
    if (bubble_i) begin
      wb_d = MEM_WB_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= MEM_WB_BUBBLE;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign wb_en_o    = wb_q.wb_en;
  assign mem_r_en_o = wb_q.mem_r_en;
  assign alu_res_o  = wb_q.alu_res;
  assign mem_data_o = wb_q.mem_data;
  assign dest_o     = wb_q.dest;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// mem_access_stage: ARM MEM stage; runs a req/ack data-memory transaction per load/store and
// stalls upstream meanwhile. Optional request watchdog: define MEM_TIMEOUT_EN. Rev 1.0
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BASE      = DEFAULT_ADDR_BASE,
  parameter int          ADDR_W         = 16,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_ENIn,
  input  logic              MEM_R_ENIn,
  input  logic              MEM_W_ENIn,
  input  logic [31:0]       ALU_ResIn,
  input  logic [31:0]       Val_RmIn,
  input  logic [3:0]        DestIn,
  input  logic              memAckIn,
  input  logic [31:0]       memRDataIn,
  output logic              freezeOut,
  output logic              memReqOut,
  output logic              memWEOut,
  output logic [ADDR_W-1:0] memAddrOut,
  output logic [31:0]       memWDataOut,
  output logic              WB_ENOut,
  output logic              MEM_R_ENOut,
  output logic [31:0]       ALU_ResOut,
  output logic [31:0]       memDataOut,
  output logic [3:0]        DestOut,
  output logic              errOut
);

  mem_state_t        state_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              mem_op;
  logic              tmo_hit;
  logic [31:0]       wb_data;

  assign mem_op    = MEM_R_ENIn | MEM_W_ENIn;
  assign freezeOut = (state_q == REQ) || ((state_q == IDLE) && mem_op);
  // Only the DONE cycle forwards captured data; plain ALU ops write back zero.
  assign wb_data   = (state_q == DONE) ? rdata_q : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            addr_q  <= ADDR_W'((ALU_ResIn - ADDR_BASE) >> 2);
            wdata_q <= Val_RmIn;
            we_q    <= MEM_W_ENIn;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (memAckIn) begin
            rdata_q <= we_q ? 32'd0 : memRDataIn;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= DONE;
          end else if (tmo_hit) begin
            rdata_q <= 32'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;

  // Counter value equals the number of completed REQ cycles, so the last allowed one hits here.
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (state_q == IDLE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == REQ) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      if (!memAckIn && tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign errOut = err_q;
`else
  assign tmo_hit = 1'b0;
  // Without the watchdog the flag can never assert.
  assign errOut  = (TIMEOUT_CYCLES < 0);
`endif

  assign memReqOut   = req_q;
  assign memWEOut    = we_q;
  assign memAddrOut  = addr_q;
  assign memWDataOut = wdata_q;

  mem_wb_reg u_mem_wb_reg (
    .clk        (clk),
    .rst_n      (rst),
    .bubble_i   (freezeOut),
    .wb_en_i    (WB_ENIn),
    .mem_r_en_i (MEM_R_ENIn),
    .alu_res_i  (ALU_ResIn),
    .mem_data_i (wb_data),
    .dest_i     (DestIn),
    .wb_en_o    (WB_ENOut),
    .mem_r_en_o (MEM_R_ENOut),
    .alu_res_o  (ALU_ResOut),
    .mem_data_o (memDataOut),
    .dest_o     (DestOut)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// tb_mem_access_stage: vector table, random transactions against a transaction-level model,
// plus reset-abort and watchdog sequences. Rev 1.0
module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1 << 30;
`endif
  localparam int LOOP_MAX = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_ENIn, MEM_R_ENIn, MEM_W_ENIn;
  logic [31:0] ALU_ResIn, Val_RmIn;
  logic [3:0]  DestIn;
  logic        memAckIn;
  logic [31:0] memRDataIn;
  logic        freezeOut, memReqOut, memWEOut;
  logic [15:0] memAddrOut;
  logic [31:0] memWDataOut;
  logic        WB_ENOut, MEM_R_ENOut;
  logic [31:0] ALU_ResOut, memDataOut;
  logic [3:0]  DestOut;
  logic        errOut;

  always #5 clk = ~clk;

  mem_access_stage #(
    .ADDR_BASE      (1024),
    .ADDR_W         (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .WB_ENIn     (WB_ENIn),
    .MEM_R_ENIn  (MEM_R_ENIn),
    .MEM_W_ENIn  (MEM_W_ENIn),
    .ALU_ResIn   (ALU_ResIn),
    .Val_RmIn    (Val_RmIn),
    .DestIn      (DestIn),
    .memAckIn    (memAckIn),
    .memRDataIn  (memRDataIn),
    .freezeOut   (freezeOut),
    .memReqOut   (memReqOut),
    .memWEOut    (memWEOut),
    .memAddrOut  (memAddrOut),
    .memWDataOut (memWDataOut),
    .WB_ENOut    (WB_ENOut),
    .MEM_R_ENOut (MEM_R_ENOut),
    .ALU_ResOut  (ALU_ResOut),
    .memDataOut  (memDataOut),
    .DestOut     (DestOut),
    .errOut      (errOut)
  );

  typedef struct {
    logic        wb, rd, wr;
    logic [31:0] alu, rm;
    logic [3:0]  dest;
    int          k;
    logic [31:0] rdata;
    logic        exp_wb, exp_rd;
    logic [31:0] exp_alu, exp_data;
    logic [3:0]  exp_dest;
    logic [15:0] exp_addr;
    int          exp_freeze;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  logic model_err = 1'b0;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic wb, logic rd, logic wr, logic [31:0] alu, logic [31:0] rm,
                              logic [3:0] dest, int k, logic [31:0] rdata);
    vec_t v;
    v = '{default: '0};
    v.wb = wb; v.rd = rd; v.wr = wr; v.alu = alu; v.rm = rm;
    v.dest = dest; v.k = k; v.rdata = rdata;
    return v;
  endfunction

  function automatic vec_t set_exp(vec_t v, logic ewb, logic erd, logic [31:0] ealu,
                                   logic [31:0] edata, logic [3:0] edest, logic [15:0] eaddr,
                                   int efz);
    vec_t e;
    e = v;
    e.exp_wb = ewb; e.exp_rd = erd; e.exp_alu = ealu; e.exp_data = edata;
    e.exp_dest = edest; e.exp_addr = eaddr; e.exp_freeze = efz;
    return e;
  endfunction

  // Transaction-level reference: what write-back sees once the instruction leaves the stage.
  function automatic vec_t model(vec_t v);
    vec_t e;
    logic mem, tmo;
    e   = v;
    mem = v.rd | v.wr;
    tmo = mem && (v.k > TMO);
    e.exp_wb     = v.wb;
    e.exp_rd     = v.rd;
    e.exp_alu    = v.alu;
    e.exp_dest   = v.dest;
    e.exp_data   = (mem && !v.wr && !tmo) ? v.rdata : 32'd0;
    e.exp_addr   = 16'((v.alu - 32'd1024) / 4);
    e.exp_freeze = !mem ? 0 : ((tmo ? TMO : v.k) + 1);
    return e;
  endfunction

  task automatic run_op(input vec_t v, input logic spur);
    int   fz, rq, cyc, exp_rq;
    logic mem;
    mem = v.rd | v.wr;
    WB_ENIn = v.wb; MEM_R_ENIn = v.rd; MEM_W_ENIn = v.wr;
    ALU_ResIn = v.alu; Val_RmIn = v.rm; DestIn = v.dest;
    memAckIn = spur; memRDataIn = $urandom;
    fz = 0; rq = 0; cyc = 0;
    @(negedge clk);
    chk("entry_freeze", freezeOut, mem);
    if (freezeOut) fz++;
    @(posedge clk); #1;
    memAckIn = 1'b0;
    if (mem) begin
      while (cyc < LOOP_MAX) begin
        @(negedge clk);
        if (!freezeOut) break;
        fz++;
        if (memReqOut) rq++;
        chk("req_high", memReqOut, 1'b1);
        chk("req_addr", memAddrOut, v.exp_addr);
        chk("req_we", memWEOut, v.wr);
        chk("req_wdata", memWDataOut, v.rm);
        chk("req_bubble", WB_ENOut | MEM_R_ENOut | (|DestOut) | (|ALU_ResOut) | (|memDataOut), 1'b0);
        if (rq == v.k) begin
          memAckIn = 1'b1;
          memRDataIn = v.rdata;
        end
        @(posedge clk); #1;
        memAckIn = 1'b0;
        memRDataIn = $urandom;
        cyc++;
      end
      chk("loop_bound", cyc < LOOP_MAX, 1'b1);
      exp_rq = (v.k > TMO) ? TMO : v.k;
      chk("req_cycles", rq, exp_rq);
      chk("done_req_low", memReqOut, 1'b0);
      if (v.k > TMO) model_err = 1'b1;
      @(posedge clk); #1;
    end
    chk("freeze_cycles", fz, v.exp_freeze);
    chk("wb_en", WB_ENOut, v.exp_wb);
    chk("mem_r_en", MEM_R_ENOut, v.exp_rd);
    chk("alu_res", ALU_ResOut, v.exp_alu);
    chk("mem_data", memDataOut, v.exp_data);
    chk("dest", DestOut, v.exp_dest);
    chk("err", errOut, model_err);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"}, memReqOut, 1'b0);
    chk({tag, "_we"}, memWEOut, 1'b0);
    chk({tag, "_addr"}, memAddrOut, 16'h0);
    chk({tag, "_wdata"}, memWDataOut, 32'h0);
    chk({tag, "_wbctl"}, {WB_ENOut, MEM_R_ENOut, DestOut}, 6'h0);
    chk({tag, "_alu"}, ALU_ResOut, 32'h0);
    chk({tag, "_data"}, memDataOut, 32'h0);
    chk({tag, "_err"}, errOut, 1'b0);
  endtask

  initial begin
    vec_t v;
    int   kind;
    rst = 1'b0;
    WB_ENIn = 0; MEM_R_ENIn = 0; MEM_W_ENIn = 0;
    ALU_ResIn = 0; Val_RmIn = 0; DestIn = 0;
    memAckIn = 0; memRDataIn = 0;

    tbl[0] = set_exp(mk(1, 0, 0, 32'h5, 32'h0, 4'd3, 0, 32'h0), 1, 0, 32'h5, 32'h0, 4'd3, 16'h0, 0);
    tbl[1] = set_exp(mk(1, 1, 0, 32'd1028, 32'h1111, 4'd7, 1, 32'h12345678),
                     1, 1, 32'd1028, 32'h12345678, 4'd7, 16'd1, 2);
    tbl[2] = set_exp(mk(0, 0, 1, 32'd1032, 32'hA5A5A5A5, 4'd2, 3, 32'hDEADBEEF),
                     0, 0, 32'd1032, 32'h0, 4'd2, 16'd2, 4);
    tbl[3] = set_exp(mk(1, 1, 0, 32'd1020, 32'h0, 4'd9, 2, 32'hCAFEF00D),
                     1, 1, 32'd1020, 32'hCAFEF00D, 4'd9, 16'hFFFF, 3);
    tbl[4] = set_exp(mk(1, 1, 0, 32'd1024, 32'h0, 4'd1, 1, 32'h0BADF00D),
                     1, 1, 32'd1024, 32'h0BADF00D, 4'd1, 16'h0, 2);
    tbl[5] = set_exp(mk(0, 0, 0, 32'hFFFFFFFF, 32'h0, 4'hF, 0, 32'h0),
                     0, 0, 32'hFFFFFFFF, 32'h0, 4'hF, 16'h0, 0);

    #2;
    chk_reset_state("reset");
    chk("reset_freeze", freezeOut, 1'b0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 6; i++) run_op(tbl[i], 1'b0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0:       v = mk($urandom_range(0, 1), 0, 0, $urandom, $urandom, 4'($urandom), 0, 32'h0);
        1:       v = mk(1, 1, 0, $urandom, $urandom, 4'($urandom), $urandom_range(1, 6), $urandom);
        default: v = mk(0, 0, 1, $urandom, $urandom, 4'($urandom), $urandom_range(1, 6), $urandom);
      endcase
      run_op(model(v), 1'($urandom_range(0, 1)));
    end

`ifdef MEM_TIMEOUT_EN
    run_op(model(mk(1, 1, 0, 32'd1100, 32'h0, 4'd6, 1000, 32'h77777777)), 1'b0);
    run_op(model(mk(1, 0, 0, 32'h42, 32'h0, 4'd5, 0, 32'h0)), 1'b0);
`else
    run_op(model(mk(0, 0, 1, 32'd2048, 32'h5A5A5A5A, 4'd4, 20, 32'h0)), 1'b0);
`endif

    // Reset in the middle of a request must abort it without a clock edge.
    WB_ENIn = 1; MEM_R_ENIn = 1; MEM_W_ENIn = 0;
    ALU_ResIn = 32'd1100; Val_RmIn = 32'h13579BDF; DestIn = 4'd4;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_req_high", memReqOut, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_reset_state("abort");
    WB_ENIn = 0; MEM_R_ENIn = 0; ALU_ResIn = 0; Val_RmIn = 0; DestIn = 0;
    @(posedge clk); #1 rst = 1'b1;
    model_err = 1'b0;
    memAckIn = 1'b1; memRDataIn = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ack_req", memReqOut, 1'b0);
      chk("idle_ack_freeze", freezeOut, 1'b0);
      @(posedge clk); #1;
    end
    memAckIn = 1'b0;
    chk("idle_ack_data", memDataOut, 32'h0);
    chk("idle_ack_wb", WB_ENOut, 1'b0);

    run_op(model(mk(1, 1, 0, 32'd1036, 32'h0, 4'd8, 2, 32'h600DCAFE)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
